// File: rtl/cmv300_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : cmv300_frame_seq
// Purpose  : CMV300 capture sequencer. It handles sensor reset and frame
//            requests, captures single frames or bursts, packs pixels into
//            32-bit words and reports done, timeout and overflow status.
// Revision : 1.0 - initial release
// ============================================================================
module cmv300_frame_seq #(
  parameter int PIX_W      = 10,
  parameter int OUT_BITS   = 8,
  parameter int COLS       = 648,
  parameter int ROWS       = 488,
  parameter int RES_CYCLES = 4,
  parameter int REQ_CYCLES = 1,
  parameter int TIMEOUT    = 1048576
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [7:0]       i_num_frames,
  output logic             o_ready,
  output logic             o_done,
  output logic             o_error,
  output logic             o_overflow,
  output logic [7:0]       o_frame_cnt,
  output logic             o_sys_res,
  output logic             o_frame_req,
  input  logic             i_pix_valid,
  input  logic [PIX_W-1:0] i_pix_data,
  output logic [31:0]      o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready
);

  localparam int c_LANES     = 32 / OUT_BITS;
  localparam int c_LANE_W    = (c_LANES > 1) ? $clog2(c_LANES) : 1;
  localparam int c_FRAME_PIX = COLS * ROWS;
  localparam int c_PCNT_W    = $clog2(c_FRAME_PIX + 1);
  localparam int c_TO_W      = $clog2(TIMEOUT + 1);
  localparam int c_RES_W     = $clog2(RES_CYCLES + 1);
  localparam int c_REQ_W     = $clog2(REQ_CYCLES + 1);

  localparam logic [c_LANE_W-1:0] c_LANE_LAST = c_LANE_W'(c_LANES - 1);
  localparam logic [c_PCNT_W-1:0] c_PIX_LAST  = c_PCNT_W'(c_FRAME_PIX - 1);
  localparam logic [c_TO_W-1:0]   c_TO_LAST   = c_TO_W'(TIMEOUT - 1);
  localparam logic [c_RES_W-1:0]  c_RES_LAST  = c_RES_W'(RES_CYCLES - 1);
  localparam logic [c_REQ_W-1:0]  c_REQ_LAST  = c_REQ_W'(REQ_CYCLES - 1);

  typedef enum logic [2:0] {
    S_SYS_RES = 3'd0,
    S_IDLE    = 3'd1,
    S_REQ     = 3'd2,
    S_CAPTURE = 3'd3,
    S_FLUSH   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [c_RES_W-1:0]  r_res_cnt;
  logic                r_sys_res;
  logic [c_REQ_W-1:0]  r_req_cnt;
  logic [c_PCNT_W-1:0] r_pix_cnt;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [c_LANE_W-1:0] r_lane;
  logic [31:0]         r_pack;
  logic [7:0]          r_num;
  logic [7:0]          r_frame_cnt;
  logic                r_done;
  logic                r_error;
  logic                r_overflow;
  logic [31:0]         r_word;
  logic                r_word_valid;

  logic [OUT_BITS-1:0] w_pix;
  logic [31:0]         w_merged;
  logic [31:0]         w_emit_word;
  logic                w_emit;
  logic                w_start_acc;
  logic                w_pix_hit;
  logic                w_frame_end;
  logic                w_timeout;
  logic                w_last_frame;

  assign w_pix        = i_pix_data[PIX_W-1 -: OUT_BITS];
  // Lanes at and above r_lane are always zero, so OR-ing places the sample.
  assign w_merged     = r_pack | ({{(32-OUT_BITS){1'b0}}, w_pix} << (int'(r_lane) * OUT_BITS));
  assign w_last_frame = ((r_frame_cnt + 8'd1) == r_num);

  generate
    if (PIX_W > OUT_BITS) begin : g_unused_lsb
      logic w_unused_lsb;
      assign w_unused_lsb = ^i_pix_data[PIX_W-OUT_BITS-1:0];
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_SYS_RES;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next      = r_state;
    o_ready     = 1'b0;
    o_frame_req = 1'b0;
    w_emit      = 1'b0;
    w_emit_word = r_pack;
    w_start_acc = 1'b0;
    w_pix_hit   = 1'b0;
    w_frame_end = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_SYS_RES: begin
        if (r_sys_res) w_next = S_IDLE;
      end
      S_IDLE: begin
        o_ready = 1'b1;
        if (i_start) begin
          w_start_acc = 1'b1;
          w_next      = S_REQ;
        end
      end
      S_REQ: begin
        o_frame_req = !i_abort;
        if (i_abort) w_next = S_IDLE;
        else if (r_req_cnt == c_REQ_LAST) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_pix_hit   = i_pix_valid && !i_abort;
        w_frame_end = w_pix_hit && (r_pix_cnt == c_PIX_LAST);
        // Abort takes priority, so a simultaneous timeout never raises the error.
        w_timeout   = !i_pix_valid && !i_abort && (r_to_cnt == c_TO_LAST);
        if (w_pix_hit && (r_lane == c_LANE_LAST)) begin
          w_emit      = 1'b1;
          w_emit_word = w_merged;
        end
        if (i_abort || w_timeout) w_next = S_IDLE;
        else if (w_frame_end) w_next = S_FLUSH;
      end
      S_FLUSH: begin
        if (i_abort) begin
          w_next = S_IDLE;
        end else begin
          w_emit = (r_lane != '0);
          w_next = w_last_frame ? S_IDLE : S_REQ;
        end
      end
      default: w_next = S_SYS_RES;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res_cnt    <= '0;
      r_sys_res    <= 1'b0;
      r_req_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_to_cnt     <= '0;
      r_lane       <= '0;
      r_pack       <= '0;
      r_num        <= 8'd1;
      r_frame_cnt  <= 8'd0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_overflow   <= 1'b0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if ((r_state == S_SYS_RES) && !r_sys_res) begin
        r_res_cnt <= r_res_cnt + 1'b1;
        if (r_res_cnt == c_RES_LAST) r_sys_res <= 1'b1;
      end

      if (w_start_acc) begin
        r_num       <= (i_num_frames == 8'd0) ? 8'd1 : i_num_frames;
        r_error     <= 1'b0;
        r_overflow  <= 1'b0;
        r_frame_cnt <= 8'd0;
      end

      r_req_cnt <= (r_state == S_REQ) ? r_req_cnt + 1'b1 : '0;
      if (r_state == S_REQ) begin
        r_pix_cnt <= '0;
        r_to_cnt  <= '0;
        r_lane    <= '0;
        r_pack    <= '0;
      end

      if (w_pix_hit) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
        r_to_cnt  <= '0;
        if (r_lane == c_LANE_LAST) begin
          r_lane <= '0;
          r_pack <= '0;
        end else begin
          r_lane <= r_lane + 1'b1;
          r_pack <= w_merged;
        end
      end else if (r_state == S_CAPTURE) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_timeout) r_error <= 1'b1;

      if ((r_state == S_FLUSH) || w_timeout || (i_abort && (r_state == S_CAPTURE))) begin
        r_lane <= '0;
        r_pack <= '0;
      end

      if ((r_state == S_FLUSH) && !i_abort) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_done      <= w_last_frame;
      end

      // Single-entry output stage: the sensor cannot stall, so a busy stage drops.
      if (w_emit) begin
        if (!r_word_valid || i_word_ready) begin
          r_word       <= w_emit_word;
          r_word_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (i_word_ready) begin
        r_word_valid <= 1'b0;
      end
    end
  end

  assign o_done       = r_done;
  assign o_error      = r_error;
  assign o_overflow   = r_overflow;
  assign o_frame_cnt  = r_frame_cnt;
  assign o_sys_res    = r_sys_res;
  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: tb/tb_cmv300_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmv300_frame_seq
// Purpose  : Directed self-checking bench for cmv300_frame_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmv300_frame_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic        a_rst_n, a_start, a_abort, a_pix_valid, a_word_ready;
  logic [7:0]  a_num;
  logic [9:0]  a_pix;
  logic        a_ready, a_done, a_error, a_ovf, a_sys_res, a_freq, a_wvalid;
  logic [7:0]  a_fcnt;
  logic [31:0] a_word;

  logic        b_rst_n, b_start, b_abort, b_pix_valid, b_word_ready;
  logic [7:0]  b_num;
  logic [15:0] b_pix;
  logic        b_ready, b_done, b_error, b_ovf, b_sys_res, b_freq, b_wvalid;
  logic [7:0]  b_fcnt;
  logic [31:0] b_word;

  cmv300_frame_seq #(
    .PIX_W(10), .OUT_BITS(8), .COLS(8), .ROWS(2),
    .RES_CYCLES(4), .REQ_CYCLES(1), .TIMEOUT(16)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_start(a_start), .i_abort(a_abort),
    .i_num_frames(a_num), .o_ready(a_ready), .o_done(a_done), .o_error(a_error),
    .o_overflow(a_ovf), .o_frame_cnt(a_fcnt), .o_sys_res(a_sys_res),
    .o_frame_req(a_freq), .i_pix_valid(a_pix_valid), .i_pix_data(a_pix),
    .o_word(a_word), .o_word_valid(a_wvalid), .i_word_ready(a_word_ready)
  );

  cmv300_frame_seq #(
    .PIX_W(16), .OUT_BITS(16), .COLS(3), .ROWS(1),
    .RES_CYCLES(4), .REQ_CYCLES(1), .TIMEOUT(16)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_start(b_start), .i_abort(b_abort),
    .i_num_frames(b_num), .o_ready(b_ready), .o_done(b_done), .o_error(b_error),
    .o_overflow(b_ovf), .o_frame_cnt(b_fcnt), .o_sys_res(b_sys_res),
    .o_frame_req(b_freq), .i_pix_valid(b_pix_valid), .i_pix_data(b_pix),
    .o_word(b_word), .o_word_valid(b_wvalid), .i_word_ready(b_word_ready)
  );

  logic [31:0] a_words[$];
  logic [31:0] b_words[$];
  int   a_dones = 0;
  int   a_reqs  = 0;
  logic a_freq_q = 1'b0;

  always @(negedge clk) begin
    if (a_wvalid && a_word_ready) a_words.push_back(a_word);
    if (b_wvalid && b_word_ready) b_words.push_back(b_word);
    if (a_done) a_dones++;
    if (a_freq && !a_freq_q) a_reqs++;
    a_freq_q = a_freq;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [7:0] n);
    a_num   = n;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("start_ready_low", a_ready, 1'b0);
    check("start_req_high", a_freq, 1'b1);
  endtask

  task automatic enter_capture_a();
    int n = 0;
    while (!a_freq && n < 40) begin
      tick();
      n++;
    end
    check("req_seen", a_freq, 1'b1);
    tick();
  endtask

  // Pixel k carries 4*k, so its kept MSBs equal k.
  task automatic feed_a(input int first, input int last);
    for (int k = first; k <= last; k++) begin
      a_pix_valid = 1'b1;
      a_pix       = 10'(4 * k);
      tick();
    end
    a_pix_valid = 1'b0;
  endtask

  task automatic frame_a(input logic [7:0] exp_cnt);
    enter_capture_a();
    feed_a(1, 16);
    tick();
    check("frame_cnt", a_fcnt, exp_cnt);
  endtask

  function automatic logic [31:0] exp_word(input int w);
    return {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};
  endfunction

  initial begin
    int d0;
    int r0;
    int n;
    a_rst_n = 1'b1; a_start = 1'b0; a_abort = 1'b0; a_pix_valid = 1'b0;
    a_word_ready = 1'b1; a_num = 8'd1; a_pix = '0;
    b_rst_n = 1'b1; b_start = 1'b0; b_abort = 1'b0; b_pix_valid = 1'b0;
    b_word_ready = 1'b1; b_num = 8'd1; b_pix = '0;
    #2;
    a_rst_n = 1'b0;
    b_rst_n = 1'b0;
    tick();
    tick();
    check("rst_outputs", {a_sys_res, a_freq, a_ready, a_done, a_error, a_ovf, a_fcnt, a_wvalid, a_word}, 64'd0);

    a_rst_n = 1'b1;
    tick(); tick(); tick();
    check("sysres_low_3", a_sys_res, 1'b0);
    tick();
    check("sysres_high_4", a_sys_res, 1'b1);
    check("ready_lag", a_ready, 1'b0);
    tick();
    check("ready_up", a_ready, 1'b1);

    // Single frame
    a_words.delete();
    d0 = a_dones;
    start_a(8'd1);
    frame_a(8'd1);
    check("single_done", a_done, 1'b1);
    check("single_ready", a_ready, 1'b1);
    tick();
    check("single_done_pulse", a_done, 1'b0);
    check("single_done_cnt", a_dones - d0, 1);
    check("single_nwords", a_words.size(), 4);
    for (int w = 0; w < 4; w++) check($sformatf("single_word%0d", w), a_words[w], exp_word(w));

    // Burst of three
    a_words.delete();
    d0 = a_dones;
    r0 = a_reqs;
    start_a(8'd3);
    frame_a(8'd1);
    check("burst_no_early_done", a_done, 1'b0);
    frame_a(8'd2);
    frame_a(8'd3);
    check("burst_done", a_done, 1'b1);
    tick();
    check("burst_done_cnt", a_dones - d0, 1);
    check("burst_reqs", a_reqs - r0, 3);
    check("burst_nwords", a_words.size(), 12);

    // Zero frames means one
    d0 = a_dones;
    r0 = a_reqs;
    start_a(8'd0);
    frame_a(8'd1);
    check("nf0_done", a_done, 1'b1);
    tick();
    check("nf0_reqs", a_reqs - r0, 1);
    check("nf0_idle", a_ready, 1'b1);

    // Overflow: hold ready low across two completed words
    a_words.delete();
    a_word_ready = 1'b0;
    start_a(8'd1);
    enter_capture_a();
    feed_a(1, 8);
    check("ovf_set", a_ovf, 1'b1);
    check("ovf_valid", a_wvalid, 1'b1);
    check("ovf_held_word", a_word, exp_word(0));
    a_word_ready = 1'b1;
    feed_a(9, 16);
    tick();
    check("ovf_done", a_done, 1'b1);
    tick();
    check("ovf_nwords", a_words.size(), 3);
    check("ovf_w0", a_words[0], exp_word(0));
    check("ovf_w1", a_words[1], exp_word(2));
    check("ovf_w2", a_words[2], exp_word(3));
    check("ovf_sticky", a_ovf, 1'b1);

    // Timeout after 16 idle cycles mid-frame
    a_words.delete();
    d0 = a_dones;
    start_a(8'd1);
    check("ovf_clear", a_ovf, 1'b0);
    enter_capture_a();
    feed_a(1, 5);
    repeat (15) tick();
    check("to_not_yet", a_error, 1'b0);
    tick();
    check("to_error", a_error, 1'b1);
    check("to_ready", a_ready, 1'b1);
    repeat (3) tick();
    check("to_no_done", a_dones - d0, 0);
    check("to_nwords", a_words.size(), 1);
    check("to_error_held", a_error, 1'b1);

    // Abort mid-frame
    a_words.delete();
    d0 = a_dones;
    start_a(8'd1);
    check("err_clear", a_error, 1'b0);
    enter_capture_a();
    feed_a(1, 6);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    check("abort_ready", a_ready, 1'b1);
    check("abort_no_err", a_error, 1'b0);
    check("abort_req_low", a_freq, 1'b0);
    repeat (3) tick();
    check("abort_no_done", a_dones - d0, 0);
    check("abort_nwords", a_words.size(), 1);
    a_words.delete();
    start_a(8'd1);
    frame_a(8'd1);
    tick();
    check("post_abort_nwords", a_words.size(), 4);
    check("post_abort_w0", a_words[0], exp_word(0));

    // Asynchronous reset mid-capture
    a_word_ready = 1'b0;
    start_a(8'd1);
    enter_capture_a();
    feed_a(1, 6);
    check("pre_rst_valid", a_wvalid, 1'b1);
    #2;
    a_rst_n = 1'b0;
    #1;
    check("async_rst", {a_sys_res, a_freq, a_ready, a_done, a_error, a_ovf, a_fcnt, a_wvalid, a_word}, 64'd0);
    tick();
    a_rst_n = 1'b1;
    a_word_ready = 1'b1;
    repeat (4) tick();
    check("rst_sysres_again", a_sys_res, 1'b1);

    // Partial flush with 16-bit lanes
    b_rst_n = 1'b1;
    n = 0;
    while (!b_ready && n < 20) begin
      tick();
      n++;
    end
    check("b_ready", b_ready, 1'b1);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    b_pix_valid = 1'b1;
    b_pix = 16'h1111; tick();
    b_pix = 16'h2222; tick();
    b_pix = 16'h3333; tick();
    b_pix_valid = 1'b0;
    tick();
    check("b_done", b_done, 1'b1);
    check("b_fcnt", b_fcnt, 8'd1);
    tick();
    check("b_nwords", b_words.size(), 2);
    check("b_w0", b_words[0], 32'h2222_1111);
    check("b_w1", b_words[1], 32'h0000_3333);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cmv300_frame_seq.md
# cmv300_frame_seq

Parametrised successor to the CMV300 capture controller. It sequences sensor reset and frame requests, and captures single frames or N-frame bursts. It packs qualified pixel samples into 32-bit words for the downstream FIFO and reports done, timeout and overflow status. Sits between the sensor pad/resync logic, which delivers `i_pix_valid`/`i_pix_data` already in the `i_clk` domain, and the host-side readout FIFO.

## Interface
- `PIX_W`, 10: sensor sample width.
- `OUT_BITS`, 8: MSBs kept per pixel; legal values are 8 or 16. `LANES = 32/OUT_BITS`.
- `COLS`, 648: pixels per line.
- `ROWS`, 488: lines per frame. `FRAME_PIX = COLS*ROWS`.
- `RES_CYCLES`, 4: sensor reset low time, in cycles (≥1).
- `REQ_CYCLES`, 1: `o_frame_req` high time, in cycles (≥1).
- `TIMEOUT`, 1048576: idle cycles without a pixel before the error state (≥2).

Ports:
- `i_clk` in 1: single clock; every signal is in this domain.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_start` in 1: start a capture; sampled only in S_IDLE.
- `i_abort` in 1: cancel the capture in progress.
- `i_num_frames` in 8: burst length, latched at start; 0 is treated as 1.
- `o_ready` out 1: high in S_IDLE.
- `o_done` out 1: 1-cycle pulse at the end of the burst.
- `o_error` out 1: timeout flag; held until the next accepted start.
- `o_overflow` out 1: sticky word-drop flag; cleared on accepted start.
- `o_frame_cnt` out 8: frames completed in the current burst.
- `o_sys_res` out 1: sensor reset, active-low.
- `o_frame_req` out 1: sensor frame request.
- `i_pix_valid` in 1: pixel strobe (DVAL-qualified).
- `i_pix_data` in `PIX_W`: pixel value.
- `o_word` out 32: packed pixels; lane 0 (first pixel) sits in bits `[OUT_BITS-1:0]`.
- `o_word_valid` out 1: `o_word` holds a word.
- `i_word_ready` in 1: downstream accepts the word, typically `~prog_full`.

## Operation
- Reset values: `o_sys_res`=0, `o_frame_req`=0, `o_ready`=0, `o_done`=0, `o_error`=0, `o_overflow`=0, `o_frame_cnt`=0, `o_word`=0, `o_word_valid`=0, state S_SYS_RES.
- **S_SYS_RES:** hold `o_sys_res`=0 for `RES_CYCLES` cycles, then drive it to 1 and go to S_IDLE.
- **S_IDLE:** `o_ready`=1. When `i_start`=1:
  - latch `i_num_frames`;
  - clear `o_error`, `o_overflow` and `o_frame_cnt`;
  - drive `o_ready`=0 and go to S_REQ.
- **S_REQ:** `o_frame_req`=1 for `REQ_CYCLES` cycles. Then clear the pixel counter, lane index and timeout counter, and go to S_CAPTURE.
- **S_CAPTURE:**
  - Each `i_pix_valid` places `i_pix_data[PIX_W-1:PIX_W-OUT_BITS]` into the current lane and increments the pixel counter.
  - When the last lane fills, the word is emitted and the lane index wraps to 0.
  - When the pixel counter reaches `FRAME_PIX`, go to S_FLUSH. Valid pixels arriving after that are ignored.
- **S_FLUSH:** if the lane index is nonzero, emit the partial word with the unused upper lanes zero. Then increment `o_frame_cnt`.
  - If `o_frame_cnt` equals the latched count, pulse `o_done` and go to S_IDLE.
  - Otherwise go to S_REQ.
- **Emit rule:** the output register holds a single entry.
  - If the register is empty, or `i_word_ready`=1 this cycle, the new word is loaded.
  - Otherwise the new word is dropped and `o_overflow` is set.
  - Pixels are never stalled, because the sensor cannot be back-pressured.
  - `o_word_valid` clears when `i_word_ready`=1 and no new word is being loaded.
- **Timeout:** in S_CAPTURE, a counter counts cycles without `i_pix_valid` and resets on every valid.
  - When it reaches `TIMEOUT`, set `o_error`=1, drop the partial word, and go to S_IDLE.
  - No `o_done` pulse is issued.
- **Abort:** `i_abort`=1 in S_REQ, S_CAPTURE or S_FLUSH does the following:
  - drive `o_frame_req`=0;
  - discard the partial word, keeping a word already held in the output register;
  - go to S_IDLE with no `o_done` and no error.
- `i_start` outside S_IDLE is ignored; it is not queued.
- Abort and timeout in the same cycle: abort wins, and `o_error` stays 0.
- Pixel counter is `clog2(FRAME_PIX+1)` bits wide. The timeout counter is `clog2(TIMEOUT+1)` bits wide.

## Timing
- After `i_rst_n` deasserts, `o_sys_res` stays 0 for exactly `RES_CYCLES` rising edges.
- `o_ready`=1 one cycle after `o_sys_res` rises.
- Start accepted at edge t: `o_ready`=0 and `o_frame_req`=1 from t+1 through t+`REQ_CYCLES`.
- Pixel completing a word at edge t: `o_word_valid`=1 at t+1.
- Last pixel of a frame at edge t:
  - S_FLUSH at t+1;
  - a partial word, if any, is valid at t+2;
  - `o_done` pulses at t+2 when the burst is complete;
  - otherwise `o_frame_req` rises at t+2.
- Async reset mid-capture: all outputs take their reset values immediately and the state returns to S_SYS_RES.

## Test plan
- **Reset/start, single frame:** `RES_CYCLES`=4, `COLS`=8, `ROWS`=2, `OUT_BITS`=8. Release reset, pulse start, feed 16 pixels with values 0x004..0x040, `i_word_ready`=1 → `o_sys_res` low exactly 4 cycles, then 4 words (first word 0x04030201), `o_frame_cnt`=1, one `o_done` pulse, `o_ready` back to 1.
- **Partial flush:** `COLS`=3, `ROWS`=1, `OUT_BITS`=16 → words 0x(p1)(p0) and 0x0000(p2).
- **Burst:** `i_num_frames`=3 → three `o_frame_req` pulses, `o_frame_cnt` 1→2→3, a single `o_done`. With `i_num_frames`=0 → exactly one frame.
- **Overflow:** hold `i_word_ready`=0 for 2 completed words → first word held, second dropped, `o_overflow`=1. The flag clears on the next start.
- **Timeout:** `TIMEOUT`=16, stop pixels mid-frame → `o_error`=1 after 16 idle cycles, no `o_done`, `o_ready`=1.
- **Abort and mid-capture reset:** assert `i_abort` mid-frame → S_IDLE with no `o_done`. Assert `i_rst_n`=0 mid-frame → all outputs at reset values immediately.
